// File: rtl/shallow_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// shallow_fifo_wr_arbiter
// Round-robin arbiter sharing one FIFO write port between NUM_REQ
// valid/ready requesters. A grant is held for one burst of up to MAX_BURST
// beats, or until the granted requester flags req_last. New grants are held
// off while the FIFO reports prog_full or full. Individual beats are stalled
// only by full.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req_valid       per-requester beat valid
//   req_data        requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last        per-requester final-beat marker
//   req_ready       per-requester ready; only the granted bit can be high
//   fifo_wr_en      FIFO write strobe (combinational from the accepted beat)
//   fifo_wr_data    FIFO write data (granted requester's slice)
//   fifo_full       FIFO full, stalls beats
//   fifo_prog_full  FIFO programmable-full, blocks new grants
//   grant_active    a burst grant is currently held
//   grant_id        index of the current or most recent grant
// ---------------------------------------------------------------------------
module shallow_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  input  logic                          fifo_prog_full,
  output logic                          grant_active,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [ID_W-1:0]  sel;
  logic [ID_W-1:0]  idx;
  logic             beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      grant_id_q   <= ID_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    beat_cnt_d   = beat_cnt_q;
    req_ready    = '0;
    beat         = 1'b0;
    sel          = last_grant_q;
    idx          = last_grant_q;

    // Scan from farthest to nearest so the nearest valid index after
    // last_grant is the one left in sel.
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        sel = idx;
      end
    end

    case (state_q)
      IDLE: begin
        if ((|req_valid) && !fifo_prog_full && !fifo_full) begin
          grant_id_d = sel;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        req_ready[grant_id_q] = !fifo_full;
        beat = req_valid[grant_id_q] & !fifo_full;
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (req_last[grant_id_q] || (beat_cnt_q == CNT_W'(MAX_BURST - 1))) begin
            // Pointer advances only on completion; idle cycle follows.
            last_grant_d = grant_id_q;
            beat_cnt_d   = '0;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_wr_en   = beat;
  assign fifo_wr_data = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
  assign grant_active = (state_q == BURST);
  assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_shallow_fifo_wr_arbiter.sv
module tb_shallow_fifo_wr_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int MB  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_wr_data;
  logic             fifo_full;
  logic             fifo_prog_full;
  logic             grant_active;
  logic [1:0]       grant_id;

  int checks = 0;
  int errors = 0;
  int fcount = 0;

  // Requester sources: seq = beats delivered so far, pos = position in
  // current burst, blen = burst length (0 means never assert last).
  logic [NR-1:0] v;
  int seq[NR];
  int pos[NR];
  int blen[NR];

  always #5 clk = ~clk;

  shallow_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_full(fifo_full), .fifo_prog_full(fifo_prog_full),
    .grant_active(grant_active), .grant_id(grant_id)
  );

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_data[i*DW +: DW] = 8'(i*64 + seq[i] % 64);
      req_last[i] = (blen[i] != 0) && (pos[i] == blen[i] - 1);
    end
    req_valid = v;
  endtask

  // Called at the negedge: record accepted beats, move to posedge+1, advance.
  task automatic step();
    logic [NR-1:0] acc;
    acc = req_valid & req_ready;
    if (fifo_wr_en) fcount++;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        seq[i]++;
        pos[i]++;
        if (blen[i] != 0 && pos[i] == blen[i]) pos[i] = 0;
      end
    end
    drive();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    v = '0;
    fifo_full = 1'b0;
    fifo_prog_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      seq[i] = 0; pos[i] = 0; blen[i] = 0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    fcount = 0;
  endtask

  task automatic test_reset();
    reset_dut();
    req_data = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'h0 || fifo_wr_en !== 1'b0 || grant_active !== 1'b0 || fifo_wr_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_idle c=%0d ready=%h wr=%b ga=%b data=%h expected all 0", c, req_ready, fifo_wr_en, grant_active, fifo_wr_data);
      end
      checks++;
      if (grant_id !== 2'd3) begin
        errors++;
        $display("FAIL reset_gid c=%0d got %0d expected 3", c, grant_id);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_two_req();
    logic       e_ga[6]  = '{0, 1, 1, 0, 1, 1};
    logic [1:0] e_gid[6] = '{3, 0, 0, 0, 2, 2};
    logic [7:0] e_dat[6] = '{0, 8'd0, 8'd1, 0, 8'd128, 8'd129};
    reset_dut();
    blen[0] = 2; blen[2] = 2;
    for (int c = 0; c < 7; c++) begin
      v = (c < 3) ? 4'b0101 : (c < 6) ? 4'b0100 : 4'b0000;
      drive();
      @(negedge clk);
      if (c < 6) begin
        checks++;
        if (grant_active !== e_ga[c] || fifo_wr_en !== e_ga[c]) begin
          errors++;
          $display("FAIL two_req_ga c=%0d ga=%b wr=%b expected %b", c, grant_active, fifo_wr_en, e_ga[c]);
        end
        checks++;
        if (grant_id !== e_gid[c]) begin
          errors++;
          $display("FAIL two_req_gid c=%0d got %0d expected %0d", c, grant_id, e_gid[c]);
        end
        if (e_ga[c]) begin
          checks++;
          if (fifo_wr_data !== e_dat[c]) begin
            errors++;
            $display("FAIL two_req_data c=%0d got %h expected %h", c, fifo_wr_data, e_dat[c]);
          end
        end
      end
      step();
    end
    checks++;
    if (fcount != 4) begin
      errors++;
      $display("FAIL two_req_count got %0d expected 4", fcount);
    end
  endtask

  task automatic test_all_valid();
    int b, k, bt;
    logic eg;
    reset_dut();
    v = 4'hF;
    drive();
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      eg = (c > 0) && (c % 5 != 0);
      checks++;
      if (grant_active !== eg || fifo_wr_en !== eg) begin
        errors++;
        $display("FAIL all_valid_ga c=%0d ga=%b wr=%b expected %b", c, grant_active, fifo_wr_en, eg);
      end
      if (eg) begin
        b = (c - 1) / 5; k = b % 4; bt = (c - 1) % 5;
        checks++;
        if (grant_id !== 2'(k) || fifo_wr_data !== 8'(k*64 + (b/4)*4 + bt)) begin
          errors++;
          $display("FAIL all_valid_beat c=%0d gid=%0d data=%h expected gid=%0d data=%h", c, grant_id, fifo_wr_data, k, 8'(k*64 + (b/4)*4 + bt));
        end
      end
      step();
    end
  endtask

  task automatic test_full_stall();
    logic [7:0] got[$];
    reset_dut();
    v = 4'b0001;
    for (int c = 0; c < 9; c++) begin
      fifo_full = (c >= 2 && c <= 4);
      drive();
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        checks++;
        if (req_ready !== 4'h0 || fifo_wr_en !== 1'b0 || grant_active !== 1'b1) begin
          errors++;
          $display("FAIL full_stall c=%0d ready=%h wr=%b ga=%b expected 0,0,1", c, req_ready, fifo_wr_en, grant_active);
        end
      end
      if (fifo_wr_en) got.push_back(fifo_wr_data);
      if (c == 8) v = '0;
      step();
    end
    fifo_full = 1'b0;
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL full_stall_count got %0d expected 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== 8'(i)) begin
          errors++;
          $display("FAIL full_stall_data beat %0d got %h expected %h", i, got[i], 8'(i));
        end
      end
    end
  endtask

  task automatic test_prog_full();
    reset_dut();
    blen[1] = 2;
    v = 4'b0010;
    for (int c = 0; c < 7; c++) begin
      fifo_prog_full = (c < 5);
      drive();
      @(negedge clk);
      checks++;
      if (grant_active !== (c == 6)) begin
        errors++;
        $display("FAIL prog_full_ga c=%0d got %b expected %b", c, grant_active, (c == 6));
      end
      if (c == 6) begin
        checks++;
        if (grant_id !== 2'd1 || req_ready !== 4'b0010) begin
          errors++;
          $display("FAIL prog_full_grant gid=%0d ready=%h expected 1, 2", grant_id, req_ready);
        end
      end
      step();
    end
    v = '0;
    drive();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    v = 4'b0010;
    drive();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      step();
    end
    @(negedge clk);
    checks++;
    if (grant_active !== 1'b1 || fifo_wr_en !== 1'b1 || grant_id !== 2'd1 || fifo_wr_data !== 8'd66) begin
      errors++;
      $display("FAIL mid_beat3 ga=%b wr=%b gid=%0d data=%h expected 1,1,1,42", grant_active, fifo_wr_en, grant_id, fifo_wr_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'h0 || fifo_wr_en !== 1'b0 || grant_active !== 1'b0 || grant_id !== 2'd3) begin
      errors++;
      $display("FAIL async_reset ready=%h wr=%b ga=%b gid=%0d expected 0,0,0,3", req_ready, fifo_wr_en, grant_active, grant_id);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v = 4'b0011;
    drive();
    @(negedge clk);
    checks++;
    if (grant_active !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle ga=%b expected 0", grant_active);
    end
    step();
    @(negedge clk);
    checks++;
    if (grant_active !== 1'b1 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_winner ga=%b gid=%0d expected 1, 0", grant_active, grant_id);
    end
    step();
  endtask

  task automatic test_random();
    bit m_busy;
    int m_id, m_cnt, m_ptr, j;
    logic [NR-1:0] e_rdy;
    logic e_wr;
    reset_dut();
    m_busy = 0; m_id = NR - 1; m_cnt = 0; m_ptr = NR - 1;
    for (int i = 0; i < NR; i++) blen[i] = $urandom_range(0, 5);
    for (int c = 0; c < 600; c++) begin
      v = 4'($urandom_range(0, 15) | $urandom_range(0, 15));
      fifo_full = ($urandom_range(0, 4) == 0);
      fifo_prog_full = ($urandom_range(0, 4) == 0);
      drive();
      @(negedge clk);
      e_rdy = (m_busy && !fifo_full) ? 4'(1 << m_id) : 4'h0;
      e_wr = m_busy && v[m_id] && !fifo_full;
      checks++;
      if (grant_active !== m_busy || grant_id !== 2'(m_id)) begin
        errors++;
        $display("FAIL rnd_grant c=%0d ga=%b gid=%0d expected %b %0d", c, grant_active, grant_id, m_busy, m_id);
      end
      checks++;
      if (req_ready !== e_rdy || fifo_wr_en !== e_wr) begin
        errors++;
        $display("FAIL rnd_hs c=%0d ready=%h wr=%b expected %h %b", c, req_ready, fifo_wr_en, e_rdy, e_wr);
      end
      if (e_wr) begin
        checks++;
        if (fifo_wr_data !== 8'(m_id*64 + seq[m_id] % 64)) begin
          errors++;
          $display("FAIL rnd_data c=%0d got %h expected %h", c, fifo_wr_data, 8'(m_id*64 + seq[m_id] % 64));
        end
      end
      if (!m_busy) begin
        if (v != 0 && !fifo_prog_full && !fifo_full) begin
          for (int k = NR; k >= 1; k--) begin
            j = (m_ptr + k) % NR;
            if (v[j]) m_id = j;
          end
          m_busy = 1; m_cnt = 0;
        end
      end else if (e_wr) begin
        m_cnt++;
        if (req_last[m_id] || m_cnt == MB) begin
          m_ptr = m_id;
          m_busy = 0;
        end
      end
      step();
    end
    fifo_full = 1'b0;
    fifo_prog_full = 1'b0;
  endtask

  initial begin
    test_reset();
    test_two_req();
    test_all_valid();
    test_full_stall();
    test_prog_full();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
